// File: rtl/light_scheduler.sv
// light_scheduler: shares one motion_calc datapath across NUM_LIGHTS fixtures and writes
// their pan/tilt bytes into the back bank of a double-buffered DMX channel RAM.
module light_scheduler #(
    parameter int NUM_LIGHTS   = 2,
    parameter int CALC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        com_valid,
    input  logic [10:0] x_com,
    input  logic [9:0]  y_com,
    output logic [10:0] calc_x_com,
    output logic [9:0]  calc_y_com,
    output logic [2:0]  light_sel,
    output logic        calc_start,
    input  logic        calc_done,
    input  logic [7:0]  pan,
    input  logic [8:0]  pan_addr,
    input  logic [7:0]  tilt,
    input  logic [8:0]  tilt_addr,
    output logic        dmx_wr_en,
    output logic [9:0]  dmx_wr_addr,
    output logic [7:0]  dmx_wr_data,
    input  logic        dmx_frame_start,
    output logic        rd_bank,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_WR_PAN, S_WR_TILT, S_NEXT} state_t;

    localparam logic [2:0] LAST_SEL = 3'(NUM_LIGHTS - 1);
    localparam logic [7:0] CNT_LAST = 8'(CALC_TIMEOUT - 1);

    state_t      r_state, w_state_nxt;
    logic        r_pend_vld, r_swap_pend;
    logic [10:0] r_pend_x, r_calc_x;
    logic [9:0]  r_pend_y, r_calc_y;
    logic [7:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [7:0]  r_tilt;
    logic [8:0]  r_tilt_addr;
    logic [2:0]  r_light_sel, w_sel_nxt;
    logic        r_calc_start, w_start_nxt;
    logic        r_wr_en, w_wr_en_nxt;
    logic [9:0]  r_wr_addr, w_wr_addr_nxt;
    logic [7:0]  r_wr_data, w_wr_data_nxt;
    logic        r_rd_bank, r_busy, r_overrun, r_timeout_err;
    logic        w_consume, w_timeout, w_seq_done, w_cap;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_inc     = r_cnt + 8'd1;
        w_cnt_nxt     = r_cnt;
        w_sel_nxt     = r_light_sel;
        w_start_nxt   = 1'b0;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_consume     = 1'b0;
        w_timeout     = 1'b0;
        w_seq_done    = 1'b0;
        w_cap         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend_vld && !r_swap_pend) begin
                    w_consume   = 1'b1;
                    w_sel_nxt   = 3'd0;
                    w_start_nxt = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_cnt_nxt   = 8'd0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the final allowed cycle still counts.
                if (calc_done) begin
                    w_cap         = 1'b1;
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = {~r_rd_bank, pan_addr};
                    w_wr_data_nxt = pan;
                    w_state_nxt   = S_WR_PAN;
                end else if (w_cnt_inc == CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_NEXT;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_WR_PAN: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = {~r_rd_bank, r_tilt_addr};
                w_wr_data_nxt = r_tilt;
                w_state_nxt   = S_WR_TILT;
            end
            S_WR_TILT: begin
                w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (r_light_sel == LAST_SEL) begin
                    w_seq_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_sel_nxt   = r_light_sel + 3'd1;
                    w_start_nxt = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= 8'd0;
            r_pend_vld    <= 1'b0;
            r_swap_pend   <= 1'b0;
            r_calc_x      <= 11'd0;
            r_calc_y      <= 10'd0;
            r_light_sel   <= 3'd0;
            r_calc_start  <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= 10'd0;
            r_wr_data     <= 8'd0;
            r_rd_bank     <= 1'b0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_light_sel  <= w_sel_nxt;
            r_calc_start <= w_start_nxt;
            r_wr_en      <= w_wr_en_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            // A strobe coinciding with consumption refills pend without counting as a drop.
            r_pend_vld   <= com_valid | (r_pend_vld & ~w_consume);
            if (com_valid && r_pend_vld && !w_consume) r_overrun <= 1'b1;
            if (w_timeout) r_timeout_err <= 1'b1;
            if (w_consume) begin
                r_calc_x <= r_pend_x;
                r_calc_y <= r_pend_y;
            end
            if (r_swap_pend && dmx_frame_start) begin
                r_rd_bank   <= ~r_rd_bank;
                r_swap_pend <= 1'b0;
            end else if (w_seq_done) begin
                r_swap_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (com_valid) begin
            r_pend_x <= x_com;
            r_pend_y <= y_com;
        end
        if (w_cap) begin
            r_tilt      <= tilt;
            r_tilt_addr <= tilt_addr;
        end
    end

    assign calc_x_com  = r_calc_x;
    assign calc_y_com  = r_calc_y;
    assign light_sel   = r_light_sel;
    assign calc_start  = r_calc_start;
    assign dmx_wr_en   = r_wr_en;
    assign dmx_wr_addr = r_wr_addr;
    assign dmx_wr_data = r_wr_data;
    assign rd_bank     = r_rd_bank;
    assign busy        = r_busy;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;
endmodule
